// File: rtl/cpu_pkg.sv
// Shared datapath types and sizes used by decode, datapath and the register file.
package cpu_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WORD_W     = 32;

  typedef logic [0:REG_ADDR_W-1] reg_addr_t;
  typedef logic [0:WORD_W-1]     word_t;

endpackage

// File: rtl/reg_read_port.sv
// Combinational read port: selects one word from the array, forcing register 0 to read zero.
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [0:DATA_W-1] regs_i [2**ADDR_W],
  input  logic [0:ADDR_W-1] addr_i,
  output logic [0:DATA_W-1] data_o
);

  // R0 storage may hold X before the first reset, so the override is mandatory.
  always_comb begin
    data_o = '0;
    if (addr_i != '0) begin
      data_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, R0 hardwired to zero.
module register_file
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] rd,
  input  logic [0:ADDR_W-1] ra,
  input  logic [0:ADDR_W-1] rb,
  input  logic [0:DATA_W-1] busW,
  input  logic              writeEnable,
  output logic [0:DATA_W-1] busA,
  output logic [0:DATA_W-1] busB
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [0:DATA_W-1] regs_q [DEPTH];

  // Reset wins over a coincident write; writes to R0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEnable && (rd != '0)) begin
      regs_q[rd] <= busW;
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .regs_i (regs_q),
    .addr_i (ra),
    .data_o (busA)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .regs_i (regs_q),
    .addr_i (rb),
    .data_o (busB)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [0:4]  rd;
  logic [0:4]  ra;
  logic [0:4]  rb;
  logic [0:31] busW;
  logic        writeEnable;
  logic [0:31] busA;
  logic [0:31] busB;

  int compared;
  int mismatched;

  register_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd          (rd),
    .ra          (ra),
    .rb          (rb),
    .busW        (busW),
    .writeEnable (writeEnable),
    .busA        (busA),
    .busB        (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [0:31] obs, input logic [0:31] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [0:4] addr, input logic [0:31] data);
    reset = 1'b0; writeEnable = 1'b1; rd = addr; busW = data;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [0:4] addr, input logic [0:31] exp);
    ra = addr;
    #1;
    check(tag, busA, exp);
  endtask

  task automatic read_b(input string tag, input logic [0:4] addr, input logic [0:31] exp);
    rb = addr;
    #1;
    check(tag, busB, exp);
  endtask

  initial begin
    logic [0:31] w;
    compared = 0; mismatched = 0;
    reset = 1'b1; writeEnable = 1'b0; rd = '0; ra = '0; rb = '0; busW = '0;
    #2;
    read_a("r0_before_reset", 5'd0, 32'h0000_0000);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_a("reset_state_a", 5'(i), 32'h0000_0000);
      read_b("reset_state_b", 5'(31 - i), 32'h0000_0000);
    end

    write_reg(5'd7, 32'hDEAD_BEEF);
    read_a("r7_written", 5'd7, 32'hDEAD_BEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ra = 5'd7; rb = 5'd7;
    #1;
    check("reset_clears_a", busA, 32'h0000_0000);
    check("reset_clears_b", busB, 32'h0000_0000);

    write_reg(5'd3, 32'h0101_0101);
    read_a("basic_write_r3", 5'd3, 32'h0101_0101);

    write_reg(5'd15, 32'h0000_0009);
    ra = 5'd15; rb = 5'd3;
    #1;
    check("port_indep_a", busA, 32'h0000_0009);
    check("port_indep_b", busB, 32'h0101_0101);

    ra = 5'd15; rb = 5'd15;
    #1;
    check("same_addr_a", busA, 32'h0000_0009);
    check("same_addr_b", busB, 32'h0000_0009);

    writeEnable = 1'b0; rd = 5'd3; busW = 32'hFFFF_FFFF;
    tick();
    read_a("we0_keeps_r3", 5'd3, 32'h0101_0101);
    write_reg(5'd0, 32'h1234_5678);
    read_a("r0_write_dropped", 5'd0, 32'h0000_0000);
    read_b("r0_drop_keeps_r3", 5'd3, 32'h0101_0101);

    write_reg(5'd20, 32'h8000_0001);
    ra = 5'd20;
    #1;
    w = busA;
    check("msb_is_bit0", {31'd0, w[0]}, 32'h0000_0001);
    check("lsb_is_bit31", {31'd0, w[31]}, 32'h0000_0001);

    // rd/busW wiggle between edges; only the values at the edge count.
    writeEnable = 1'b1; rd = 5'd21; busW = 32'hCAFE_F00D;
    #2;
    rd = 5'd22; busW = 32'h0BAD_CAFE;
    tick();
    writeEnable = 1'b0;
    read_a("sampled_at_edge_r22", 5'd22, 32'h0BAD_CAFE);
    read_b("not_written_r21", 5'd21, 32'h0000_0000);

    write_reg(5'd5, 32'h5555_5555);
    read_a("r5_before_reset", 5'd5, 32'h5555_5555);
    reset = 1'b1; writeEnable = 1'b1; rd = 5'd5; busW = 32'hAAAA_AAAA;
    tick();
    reset = 1'b0; writeEnable = 1'b0;
    read_a("reset_beats_write", 5'd5, 32'h0000_0000);
    for (int i = 0; i < 32; i++) begin
      read_b("all_zero_after_reset", 5'(i), 32'h0000_0000);
    end

    write_reg(5'd9, 32'h1111_1111);
    writeEnable = 1'b1; rd = 5'd9; busW = 32'h2222_2222; ra = 5'd9;
    #1;
    check("rdw_before_edge", busA, 32'h1111_1111);
    tick();
    writeEnable = 1'b0;
    check("rdw_after_edge", busA, 32'h2222_2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file for the single-cycle datapath. It provides two combinational read ports (busA, busB) for the instruction's source operands and one clocked write port for the destination register. Register 0 is hardwired to zero.

## Interface

Parameters:
- DATA_W, default 32: register width; bit 0 is the MSB (`[0:DATA_W-1]` numbering).
- ADDR_W, default 5: register-number width; depth is 2**ADDR_W = 32.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state changes occur on its rising edge.
- reset  input  1  synchronous, active-high; clears every register.
- rd  input  [0:4]  destination register number.
- ra  input  [0:4]  source 1 register number, drives busA.
- rb  input  [0:4]  source 2 register number, drives busB.
- busW  input  [0:31]  data to write into rd.
- writeEnable  input  1  when 1, write busW into rd at the next rising edge.
- busA  output  [0:31]  contents of register ra.
- busB  output  [0:31]  contents of register rb.

## Operation

- Storage: 32 registers of 32 bits; R0 is constant zero.
- Reads:
  - busA = R[ra], busB = R[rb]; purely combinational, with no clock or enable.
  - ra == 0 or rb == 0 → the bus reads 0x00000000.
  - ra == rb is legal; both buses show the same value.
- Write, on the rising edge of clk:
  - Condition: reset == 0, writeEnable == 1, rd != 0.
  - Action: R[rd] ← busW.
  - rd == 0 → the write is silently dropped.
- Reset, on the rising edge of clk with reset == 1:
  - All registers ← 0.
  - Reset has priority over a simultaneous write; the write is lost.
- Bit order is big-endian: bit 0 is the MSB. Values are stored and returned unchanged, with no sign or width conversion.
- No internal write-to-read bypass.

## Timing

- Read latency is 0 cycles (combinational from ra/rb and register state).
- Write latency is 1 edge: the new value appears on busA/busB just after the rising edge that commits it.
- Read during write, same cycle and same address: the bus shows the old value before the edge and the new value after it.
- Reset value of outputs: after a reset edge, busA = busB = 0x00000000 for every address until a later write.
- Reset asserted mid-operation clears everything at the next edge. Registers written earlier do not survive.
- Before the first reset edge, register contents are undefined, except R0, which always reads 0.
- Changing rd or busW between edges has no effect. Only the values present at the rising edge are sampled.

## Structure

- Shared package (`cpu_pkg`) holds:
  - REG_COUNT = 32, REG_ADDR_W = 5, WORD_W = 32;
  - `reg_addr_t` (`[0:4]`) and `word_t` (`[0:31]`) types, used by decode and datapath.
- One natural sub-module: `reg_read_port`, a 32:1 word mux with the zero override for address 0. It is instantiated twice, for busA and busB.
- Write decode and the storage array live in the top module.

## Test plan

- Reset clears:
  - Stimulus: write 0xDEADBEEF to R7; assert reset for one edge; set ra = 7, rb = 7.
  - Required: busA = busB = 0x00000000.
- Basic write/read:
  - Stimulus: reset = 0, writeEnable = 1, rd = 3, busW = 0x01010101; clock one edge; set ra = 3.
  - Required: busA = 0x01010101.
- Second register, port independence:
  - Stimulus: rd = 15, busW = 9; clock one edge; set ra = 15, rb = 3.
  - Required: busA = 0x00000009, busB = 0x01010101.
- Write disable and R0 protection:
  - Stimulus: writeEnable = 0, rd = 3, busW = 0xFFFFFFFF, clock one edge; then writeEnable = 1, rd = 0, busW = 0x12345678, clock one edge.
  - Required: R3 still 0x01010101; ra = 0 reads 0x00000000.
- Reset beats write:
  - Stimulus: reset = 1, writeEnable = 1, rd = 5, busW = 0xAAAAAAAA on the same edge.
  - Required: R5 = 0, and all other registers are 0.
- Read-during-write:
  - Stimulus: ra = rd = 9, R9 = 0x11111111, busW = 0x22222222.
  - Required: busA = 0x11111111 before the edge and 0x22222222 after it.
